// File: rtl/reg_file_master_if.sv
// rtl/reg_file_master_if.sv - command, write, response and register file signals of reg_file_master
interface reg_file_master_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 3
);
  logic                  Cmd_Valid;
  logic                  Cmd_Ready;
  logic                  Cmd_Write;
  logic [ADDR_WIDTH-1:0] Cmd_Addr;
  logic [LEN_WIDTH-1:0]  Cmd_Len;
  logic                  Wr_Valid;
  logic                  Wr_Ready;
  logic [DATA_WIDTH-1:0] Wr_Data;
  logic                  Rsp_Valid;
  logic                  Rsp_Ready;
  logic [DATA_WIDTH-1:0] Rsp_Data;
  logic                  Rsp_Last;
  logic                  Busy;
  logic                  Verify_Err;
  logic                  WrEn;
  logic                  RdEn;
  logic [ADDR_WIDTH-1:0] Address;
  logic [DATA_WIDTH-1:0] WrData;
  logic [DATA_WIDTH-1:0] RdData;

  modport master (
    input  Cmd_Valid, Cmd_Write, Cmd_Addr, Cmd_Len, Wr_Valid, Wr_Data, Rsp_Ready, RdData,
    output Cmd_Ready, Wr_Ready, Rsp_Valid, Rsp_Data, Rsp_Last, Busy, Verify_Err,
           WrEn, RdEn, Address, WrData
  );

  modport slave (
    output Cmd_Valid, Cmd_Write, Cmd_Addr, Cmd_Len, Wr_Valid, Wr_Data, Rsp_Ready, RdData,
    input  Cmd_Ready, Wr_Ready, Rsp_Valid, Rsp_Data, Rsp_Last, Busy, Verify_Err,
           WrEn, RdEn, Address, WrData
  );
endinterface

// File: rtl/reg_file_master.sv
// rtl/reg_file_master.sv - burst command initiator for an 8x16 register file
// Optional write read-back check enabled by defining REG_FILE_MASTER_VERIFY_EN.
module reg_file_master #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 3
) (
  input logic                CLK,
  input logic                RST,
  reg_file_master_if.master  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_WAIT  = 3'd1;
  localparam logic [2:0] WR_PULSE = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_CAPT  = 3'd4;
  localparam logic [2:0] RD_RESP  = 3'd5;
`ifdef REG_FILE_MASTER_VERIFY_EN
  localparam logic [2:0] VF_ISSUE = 3'd6;
  localparam logic [2:0] VF_CHECK = 3'd7;
`endif

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH-1:0]  beat;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  last_beat;

  assign last_beat = (beat == len);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr       <= '0;
      len        <= '0;
      beat       <= '0;
      wr_data_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Cmd_Valid) begin
            addr  <= bus.Cmd_Addr;
            len   <= bus.Cmd_Len;
            beat  <= '0;
            state <= bus.Cmd_Write ? WR_WAIT : RD_ISSUE;
          end
        end
        WR_WAIT: begin
          if (bus.Wr_Valid) begin
            wr_data_q <= bus.Wr_Data;
            state     <= WR_PULSE;
          end
        end
`ifdef REG_FILE_MASTER_VERIFY_EN
        WR_PULSE: state <= VF_ISSUE;
        VF_ISSUE: state <= VF_CHECK;
        VF_CHECK: begin
          if (last_beat) begin
            state <= IDLE;
          end else begin
            addr  <= addr + 1'b1;
            beat  <= beat + 1'b1;
            state <= WR_WAIT;
          end
        end
`else
        WR_PULSE: begin
          if (last_beat) begin
            state <= IDLE;
          end else begin
            addr  <= addr + 1'b1;
            beat  <= beat + 1'b1;
            state <= WR_WAIT;
          end
        end
`endif
        RD_ISSUE: state <= RD_CAPT;
        RD_CAPT: begin
          rsp_data_q <= bus.RdData;
          state      <= RD_RESP;
        end
        RD_RESP: begin
          // Rsp_Data stays in rsp_data_q until the consumer takes it
          if (bus.Rsp_Ready) begin
            if (last_beat) begin
              state <= IDLE;
            end else begin
              addr  <= addr + 1'b1;
              beat  <= beat + 1'b1;
              state <= RD_ISSUE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef REG_FILE_MASTER_VERIFY_EN
  logic verify_err_q;

  // Sticky across the burst; only a newly accepted command clears it
  always_ff @(posedge CLK) begin
    if (RST) begin
      verify_err_q <= 1'b0;
    end else if (state == IDLE && bus.Cmd_Valid) begin
      verify_err_q <= 1'b0;
    end else if (state == VF_CHECK && bus.RdData != wr_data_q) begin
      verify_err_q <= 1'b1;
    end
  end

  assign bus.Verify_Err = verify_err_q;
  assign bus.RdEn       = (state == RD_ISSUE) || (state == VF_ISSUE);
`else
  assign bus.Verify_Err = 1'b0;
  assign bus.RdEn       = (state == RD_ISSUE);
`endif

  assign bus.Cmd_Ready = (state == IDLE);
  assign bus.Busy      = (state != IDLE);
  assign bus.Wr_Ready  = (state == WR_WAIT);
  assign bus.WrEn      = (state == WR_PULSE);
  assign bus.Rsp_Valid = (state == RD_RESP);
  assign bus.Rsp_Last  = (state == RD_RESP) && last_beat;
  assign bus.Rsp_Data  = rsp_data_q;
  assign bus.Address   = addr;
  assign bus.WrData    = wr_data_q;
endmodule

// File: tb/tb_reg_file_master.sv
// tb/tb_reg_file_master.sv - directed vector bench for reg_file_master with a register file model
module tb_reg_file_master;
  logic CLK;
  logic RST;

  reg_file_master_if #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .LEN_WIDTH(3)) bus ();

  reg_file_master #(.ADDR_WIDTH(3), .DATA_WIDTH(16), .LEN_WIDTH(3)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic             wr;
    logic [2:0]       addr;
    logic [2:0]       len;
    logic [0:7][15:0] d;
    logic [0:7][2:0]  ea;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [8];
  logic [15:0] rd_q;
  logic        rd_force;

  logic [2:0]  wa_q [$];
  logic [15:0] wd_q [$];
  logic [2:0]  ra_q [$];
  logic [15:0] rsp_d_q [$];
  logic        rsp_l_q [$];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.WrEn) mem[bus.Address] <= bus.WrData;
    if (bus.RdEn) rd_q <= mem[bus.Address];
  end
  assign bus.RdData = rd_force ? 16'hFFFF : rd_q;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (bus.WrEn) begin
      wa_q.push_back(bus.Address);
      wd_q.push_back(bus.WrData);
    end
    if (bus.RdEn) ra_q.push_back(bus.Address);
    if (bus.Rsp_Valid && bus.Rsp_Ready) begin
      rsp_d_q.push_back(bus.Rsp_Data);
      rsp_l_q.push_back(bus.Rsp_Last);
    end
    chk("wren_rden_exclusive", 32'(bus.WrEn && bus.RdEn), 32'd0);
    chk("cmd_ready_not_busy", 32'(bus.Cmd_Ready), 32'(!bus.Busy));
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_q();
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    rsp_d_q.delete();
    rsp_l_q.delete();
  endtask

  task automatic issue_cmd(input vec_t v, input string tag);
    int n = 0;
    bus.Cmd_Valid = 1'b1;
    bus.Cmd_Write = v.wr;
    bus.Cmd_Addr  = v.addr;
    bus.Cmd_Len   = v.len;
    while (!bus.Cmd_Ready && n < 100) begin tick(); n++; end
    if (n >= 100) chk({tag, " cmd_timeout"}, 32'd1, 32'd0);
    tick();
    bus.Cmd_Valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.Busy && n < 200) begin tick(); n++; end
    if (n >= 200) chk({tag, " busy_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_cmd(input vec_t v, input string tag);
    int n;
    clear_q();
    issue_cmd(v, tag);
    if (v.wr) begin
      for (int i = 0; i <= int'(v.len); i++) begin
        bus.Wr_Valid = 1'b1;
        bus.Wr_Data  = v.d[i];
        n = 0;
        while (!bus.Wr_Ready && n < 100) begin tick(); n++; end
        if (n >= 100) chk({tag, " wr_timeout"}, 32'd1, 32'd0);
        tick();
        bus.Wr_Valid = 1'b0;
      end
    end
    wait_idle(tag);
    if (v.wr) begin
      chk({tag, " wren_count"}, 32'(wa_q.size()), 32'(v.len) + 1);
      for (int i = 0; i <= int'(v.len) && i < wa_q.size(); i++) begin
        chk($sformatf("%s wr_addr[%0d]", tag, i), 32'(wa_q[i]), 32'(v.ea[i]));
        chk($sformatf("%s wr_data[%0d]", tag, i), 32'(wd_q[i]), 32'(v.d[i]));
      end
    end else begin
      chk({tag, " rden_count"}, 32'(ra_q.size()), 32'(v.len) + 1);
      chk({tag, " rsp_count"}, 32'(rsp_d_q.size()), 32'(v.len) + 1);
      for (int i = 0; i <= int'(v.len) && i < ra_q.size(); i++)
        chk($sformatf("%s rd_addr[%0d]", tag, i), 32'(ra_q[i]), 32'(v.ea[i]));
      for (int i = 0; i <= int'(v.len) && i < rsp_d_q.size(); i++) begin
        chk($sformatf("%s rsp_data[%0d]", tag, i), 32'(rsp_d_q[i]), 32'(v.d[i]));
        chk($sformatf("%s rsp_last[%0d]", tag, i), 32'(rsp_l_q[i]), 32'(i == int'(v.len)));
      end
    end
  endtask

  vec_t vecs [9];
  vec_t v;
  logic [15:0] held;
  int          nra;

  initial begin
    vecs[0] = '{1'b1, 3'd2, 3'd1, {16'hA5A5, 16'h1234, 96'h0}, {3'd2, 3'd3, 18'd0}};
    vecs[1] = '{1'b0, 3'd2, 3'd1, {16'hA5A5, 16'h1234, 96'h0}, {3'd2, 3'd3, 18'd0}};
    vecs[2] = '{1'b1, 3'd6, 3'd3, {16'h0006, 16'h0007, 16'h0000, 16'h0001, 64'h0},
                {3'd6, 3'd7, 3'd0, 3'd1, 12'd0}};
    vecs[3] = '{1'b0, 3'd6, 3'd3, {16'h0006, 16'h0007, 16'h0000, 16'h0001, 64'h0},
                {3'd6, 3'd7, 3'd0, 3'd1, 12'd0}};
    vecs[4] = '{1'b1, 3'd5, 3'd7,
                {16'h1005, 16'h1006, 16'h1007, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004},
                {3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4}};
    vecs[5] = '{1'b0, 3'd0, 3'd0, {16'h1000, 112'h0}, {3'd0, 21'd0}};
    vecs[6] = '{1'b0, 3'd5, 3'd7,
                {16'h1005, 16'h1006, 16'h1007, 16'h1000, 16'h1001, 16'h1002, 16'h1003, 16'h1004},
                {3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4}};
    vecs[7] = '{1'b1, 3'd7, 3'd0, {16'hBEEF, 112'h0}, {3'd7, 21'd0}};
    vecs[8] = '{1'b0, 3'd7, 3'd0, {16'hBEEF, 112'h0}, {3'd7, 21'd0}};

    for (int i = 0; i < 8; i++) mem[i] = 16'h0;
    rd_q = 16'h0;
    rd_force = 1'b0;
    bus.Cmd_Valid = 1'b0; bus.Cmd_Write = 1'b0; bus.Cmd_Addr = 3'd0; bus.Cmd_Len = 3'd0;
    bus.Wr_Valid = 1'b0; bus.Wr_Data = 16'h0; bus.Rsp_Ready = 1'b1;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;

    chk("reset cmd_ready", 32'(bus.Cmd_Ready), 32'd1);
    chk("reset busy", 32'(bus.Busy), 32'd0);
    chk("reset strobes", 32'({bus.WrEn, bus.RdEn, bus.Wr_Ready, bus.Rsp_Valid, bus.Rsp_Last}), 32'd0);
    chk("reset address", 32'(bus.Address), 32'd0);
    chk("reset wrdata", 32'(bus.WrData), 32'd0);
    chk("reset rsp_data", 32'(bus.Rsp_Data), 32'd0);
    chk("reset verify_err", 32'(bus.Verify_Err), 32'd0);

    for (int i = 0; i < 9; i++) do_cmd(vecs[i], $sformatf("vec%0d", i));
    chk("verify_err after clean writes", 32'(bus.Verify_Err), 32'd0);

    // Reset in the middle of a write burst: first beat lands, the rest never do
    clear_q();
    v = '{1'b1, 3'd0, 3'd3, {16'h7777, 16'h8888, 96'h0}, {3'd0, 3'd1, 18'd0}};
    issue_cmd(v, "rst_burst");
    bus.Wr_Valid = 1'b1; bus.Wr_Data = 16'h7777;
    tick(); tick();
    bus.Wr_Valid = 1'b0;
    tick();
    chk("rst_burst in wr_wait", 32'(bus.Wr_Ready), 32'd1);
    bus.Wr_Valid = 1'b1; bus.Wr_Data = 16'h8888;
    RST = 1'b1;
    tick(); tick();
    RST = 1'b0;
    clear_q();
    chk("rst_burst busy", 32'(bus.Busy), 32'd0);
    chk("rst_burst strobes", 32'({bus.WrEn, bus.RdEn, bus.Wr_Ready, bus.Rsp_Valid}), 32'd0);
    chk("rst_burst address", 32'(bus.Address), 32'd0);
    chk("rst_burst wrdata", 32'(bus.WrData), 32'd0);
    for (int i = 0; i < 4; i++) tick();
    chk("rst_burst no further wren", 32'(wa_q.size()), 32'd0);
    bus.Wr_Valid = 1'b0;
    do_cmd('{1'b0, 3'd0, 3'd1, {16'h7777, 16'h1001, 96'h0}, {3'd0, 3'd1, 18'd0}}, "rst_readback");

    // Response back-pressure: Rsp_Ready low for 5 cycles while the first beat is offered
    clear_q();
    bus.Rsp_Ready = 1'b0;
    issue_cmd('{1'b0, 3'd7, 3'd1, {16'hBEEF, 16'h7777, 96'h0}, {3'd7, 3'd0, 18'd0}}, "stall");
    nra = 0;
    while (!bus.Rsp_Valid && nra < 50) begin tick(); nra++; end
    chk("stall rsp_valid seen", 32'(bus.Rsp_Valid), 32'd1);
    nra = ra_q.size();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("stall rsp_valid[%0d]", i), 32'(bus.Rsp_Valid), 32'd1);
      chk($sformatf("stall rsp_data[%0d]", i), 32'(bus.Rsp_Data), 32'hBEEF);
      chk($sformatf("stall rden_count[%0d]", i), 32'(ra_q.size()), 32'(nra));
    end
    bus.Rsp_Ready = 1'b1;
    wait_idle("stall");
    chk("stall rsp_count", 32'(rsp_d_q.size()), 32'd2);
    if (rsp_d_q.size() == 2) begin
      held = rsp_d_q[0];
      chk("stall rsp0", 32'(held), 32'hBEEF);
      chk("stall rsp0 last", 32'(rsp_l_q[0]), 32'd0);
      chk("stall rsp1", 32'(rsp_d_q[1]), 32'h7777);
      chk("stall rsp1 last", 32'(rsp_l_q[1]), 32'd1);
    end
    chk("stall rden_total", 32'(ra_q.size()), 32'd2);

`ifdef REG_FILE_MASTER_VERIFY_EN
    // Read-back returns all ones against a zero write: error sticks until the next command
    rd_force = 1'b1;
    do_cmd('{1'b1, 3'd3, 3'd0, {16'h0000, 112'h0}, {3'd3, 21'd0}}, "vf_write");
    rd_force = 1'b0;
    chk("vf verify_err set", 32'(bus.Verify_Err), 32'd1);
    tick(); tick();
    chk("vf verify_err sticky", 32'(bus.Verify_Err), 32'd1);
    do_cmd('{1'b0, 3'd3, 3'd0, {16'h0000, 112'h0}, {3'd3, 21'd0}}, "vf_read");
    chk("vf verify_err cleared", 32'(bus.Verify_Err), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
